// File: rtl/host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_master
// Description : Host-side command initiator. Accepts one command on a
//               parallel request port, serialises its frame into a UART
//               transmitter and gathers the response bytes from a UART
//               receiver into a single 16-bit result (or a timeout strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module host_cmd_master #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VLD,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [7:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA,
    input  logic [7:0]  CMD_OP_A,
    input  logic [7:0]  CMD_OP_B,
    input  logic [3:0]  CMD_FUNC,
    output logic [7:0]  TX_IN,
    output logic        TX_VLD,
    input  logic        BUSY,
    input  logic [7:0]  RX_out,
    input  logic        Rx_valid,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VLD,
    output logic        RSP_TIMEOUT
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SEND      = 3'd1;
    localparam logic [2:0] c_WAIT_ACC  = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_RX_WAIT   = 3'd4;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [1:0]      r_type;
    logic [7:0]      r_addr;
    logic [7:0]      r_data;
    logic [7:0]      r_op_a;
    logic [7:0]      r_op_b;
    logic [3:0]      r_func;
    logic [1:0]      r_idx;
    logic [1:0]      r_rx_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_tx_in;
    logic            r_tx_vld;
    logic [15:0]     r_rsp_data;
    logic            r_rsp_vld;
    logic            r_rsp_to;

    logic [7:0]      w_frame_byte;
    logic [1:0]      w_last_idx;
    logic [1:0]      w_rsp_len;
    logic            w_is_last;
    logic            w_rx_take;
    logic            w_rx_final;
    logic            w_to_hit;

    // Frame byte for the current index, plus frame and response lengths per command type
    always_comb begin
        w_frame_byte = 8'h00;
        w_last_idx   = 2'd1;
        w_rsp_len    = 2'd2;
        case (r_type)
            2'd0: begin
                w_last_idx = 2'd2;
                w_rsp_len  = 2'd0;
                case (r_idx)
                    2'd0:    w_frame_byte = 8'hAA;
                    2'd1:    w_frame_byte = r_addr;
                    default: w_frame_byte = r_data;
                endcase
            end
            2'd1: begin
                w_last_idx   = 2'd1;
                w_rsp_len    = 2'd1;
                w_frame_byte = (r_idx == 2'd0) ? 8'hBB : r_addr;
            end
            2'd2: begin
                w_last_idx = 2'd3;
                w_rsp_len  = 2'd2;
                case (r_idx)
                    2'd0:    w_frame_byte = 8'hCC;
                    2'd1:    w_frame_byte = r_op_a;
                    2'd2:    w_frame_byte = r_op_b;
                    default: w_frame_byte = {4'h0, r_func};
                endcase
            end
            default: begin
                w_last_idx   = 2'd1;
                w_rsp_len    = 2'd2;
                w_frame_byte = (r_idx == 2'd0) ? 8'hDD : {4'h0, r_func};
            end
        endcase
    end

    // A response byte counts only while the final frame byte drains or while awaiting the response
    assign w_is_last  = (r_idx == w_last_idx);
    assign w_rx_take  = Rx_valid &&
                        (((r_state == c_WAIT_DONE) && w_is_last && (w_rsp_len != 2'd0)) ||
                         (r_state == c_RX_WAIT));
    assign w_rx_final = w_rx_take && (r_rx_cnt == (w_rsp_len - 2'd1));
    assign w_to_hit   = (r_state == c_RX_WAIT) && (r_to_cnt == c_TO_LAST) && !w_rx_take;

    assign CMD_READY   = (r_state == c_IDLE);
    assign TX_IN       = r_tx_in;
    assign TX_VLD      = r_tx_vld;
    assign RSP_DATA    = r_rsp_data;
    assign RSP_VLD     = r_rsp_vld;
    assign RSP_TIMEOUT = r_rsp_to;

    // Command capture, frame sequencing and the TX byte handshake
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= c_IDLE;
            r_type   <= 2'd0;
            r_addr   <= 8'h00;
            r_data   <= 8'h00;
            r_op_a   <= 8'h00;
            r_op_b   <= 8'h00;
            r_func   <= 4'h0;
            r_idx    <= 2'd0;
            r_tx_in  <= 8'h00;
            r_tx_vld <= 1'b0;
        end else begin
            r_tx_vld <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (CMD_VLD) begin
                        r_type  <= CMD_TYPE;
                        r_addr  <= CMD_ADDR;
                        r_data  <= CMD_DATA;
                        r_op_a  <= CMD_OP_A;
                        r_op_b  <= CMD_OP_B;
                        r_func  <= CMD_FUNC;
                        r_idx   <= 2'd0;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (!BUSY) begin
                        r_tx_vld <= 1'b1;
                        r_tx_in  <= w_frame_byte;
                        r_state  <= c_WAIT_ACC;
                    end
                end
                c_WAIT_ACC: begin
                    if (BUSY) begin
                        r_state <= c_WAIT_DONE;
                    end
                end
                c_WAIT_DONE: begin
                    // A complete response can arrive before the last byte finishes shifting out
                    if (w_rx_final) begin
                        r_state <= c_IDLE;
                    end else if (!BUSY) begin
                        r_idx <= r_idx + 2'd1;
                        if (!w_is_last) begin
                            r_state <= c_SEND;
                        end else if (w_rsp_len == 2'd0) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_RX_WAIT;
                        end
                    end
                end
                c_RX_WAIT: begin
                    if (w_rx_final || w_to_hit) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Response assembly, completion/timeout strobes and the inactivity counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_cnt   <= 2'd0;
            r_to_cnt   <= '0;
            r_rsp_data <= 16'h0000;
            r_rsp_vld  <= 1'b0;
            r_rsp_to   <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            r_rsp_to  <= 1'b0;
            if ((r_state == c_IDLE) && CMD_VLD) begin
                r_rx_cnt <= 2'd0;
            end
            if (w_rx_take) begin
                if (w_rsp_len == 2'd1) begin
                    r_rsp_data <= {8'h00, RX_out};
                end else if (r_rx_cnt == 2'd0) begin
                    r_rsp_data[7:0] <= RX_out;
                end else begin
                    r_rsp_data[15:8] <= RX_out;
                end
                r_rx_cnt <= r_rx_cnt + 2'd1;
                if (w_rx_final) begin
                    r_rsp_vld <= 1'b1;
                end
            end else if (w_to_hit) begin
                r_rsp_to <= 1'b1;
            end
            // Counter idles at zero outside RX_WAIT, so entry into RX_WAIT starts from zero
            if ((r_state != c_RX_WAIT) || w_rx_take) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_cmd_master
// Description : Self-checking bench for host_cmd_master: vector table,
//               hand-written corner sequences and randomized commands
//               checked against a frame/response reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_cmd_master;

    localparam int c_TIMEOUT  = 20;
    localparam int c_BUSY_LEN = 10;
    localparam int c_WAIT_MAX = 1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VLD = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [7:0]  CMD_ADDR = 8'h00;
    logic [7:0]  CMD_DATA = 8'h00;
    logic [7:0]  CMD_OP_A = 8'h00;
    logic [7:0]  CMD_OP_B = 8'h00;
    logic [3:0]  CMD_FUNC = 4'h0;
    logic [7:0]  TX_IN;
    logic        TX_VLD;
    logic        BUSY = 1'b0;
    logic [7:0]  RX_out = 8'h00;
    logic        Rx_valid = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TIMEOUT;

    host_cmd_master #(
        .TO_W    (16),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .CMD_VLD     (CMD_VLD),
        .CMD_READY   (CMD_READY),
        .CMD_TYPE    (CMD_TYPE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_DATA    (CMD_DATA),
        .CMD_OP_A    (CMD_OP_A),
        .CMD_OP_B    (CMD_OP_B),
        .CMD_FUNC    (CMD_FUNC),
        .TX_IN       (TX_IN),
        .TX_VLD      (TX_VLD),
        .BUSY        (BUSY),
        .RX_out      (RX_out),
        .Rx_valid    (Rx_valid),
        .RSP_DATA    (RSP_DATA),
        .RSP_VLD     (RSP_VLD),
        .RSP_TIMEOUT (RSP_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  ad, dt, a, b;
        logic [3:0]  f;
        int          nrx;
        logic [7:0]  r0, r1;
        int          d0, d1;
        bit          junk;
        int          flen;
        logic [7:0]  fr [4];
        logic [15:0] exp_rsp;
        int          exp_vld;
        int          exp_to;
    } vec_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  tx_q [$];
    int          busy_cnt = 0;
    bit          busy_force = 1'b0;
    int          busy_viol = 0;
    int          rsp_vld_cnt = 0;
    int          rsp_to_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] rsp_at_vld = 16'h0000;
    logic [15:0] model_rsp = 16'h0000;
    logic [7:0]  hdr [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // UART TX model and output monitor: BUSY for a fixed time after each byte strobe
    always @(negedge CLK) begin
        if (!RST) begin
            busy_cnt = 0;
        end else if (TX_VLD) begin
            if (BUSY) busy_viol++;
            tx_q.push_back(TX_IN);
            busy_cnt = c_BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        BUSY = (busy_cnt > 0) || busy_force;
        if (RSP_VLD) begin
            rsp_vld_cnt++;
            rsp_at_vld = RSP_DATA;
        end
        if (RSP_TIMEOUT) rsp_to_cnt++;
        if (RSP_VLD && RSP_TIMEOUT) both_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int t, ad, dt, a, b, f, nrx, r0, r1, d0, d1, junk,
                                flen, f0, f1, f2, f3, rsp, vld, to);
        vec_t v;
        v.t = 2'(t); v.ad = 8'(ad); v.dt = 8'(dt); v.a = 8'(a); v.b = 8'(b); v.f = 4'(f);
        v.nrx = nrx; v.r0 = 8'(r0); v.r1 = 8'(r1); v.d0 = d0; v.d1 = d1; v.junk = junk[0];
        v.flen = flen;
        v.fr[0] = 8'(f0); v.fr[1] = 8'(f1); v.fr[2] = 8'(f2); v.fr[3] = 8'(f3);
        v.exp_rsp = 16'(rsp); v.exp_vld = vld; v.exp_to = to;
        return v;
    endfunction

    // Reference model: frame content and response outcome from the protocol rules
    function automatic vec_t model(input vec_t v, input logic [15:0] prev);
        logic [7:0] q [$];
        int         rlen;
        q.push_back(hdr[v.t]);
        if (v.t <= 2'd1) q.push_back(v.ad);
        if (v.t == 2'd0) q.push_back(v.dt);
        if (v.t == 2'd2) begin q.push_back(v.a); q.push_back(v.b); end
        if (v.t >= 2'd2) q.push_back({4'h0, v.f});
        v.flen = q.size();
        for (int i = 0; i < 4; i++) v.fr[i] = (i < q.size()) ? q[i] : 8'h00;
        rlen = (v.t == 2'd0) ? 0 : (v.t == 2'd1) ? 1 : 2;
        v.exp_vld = (rlen > 0 && v.nrx >= rlen) ? 1 : 0;
        v.exp_to  = (rlen > 0 && v.nrx < rlen) ? 1 : 0;
        v.exp_rsp = prev;
        if (rlen == 1 && v.nrx >= 1) v.exp_rsp = {8'h00, v.r0};
        if (rlen == 2 && v.nrx >= 1) v.exp_rsp[7:0]  = v.r0;
        if (rlen == 2 && v.nrx >= 2) v.exp_rsp[15:8] = v.r1;
        return v;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        busy_viol = 0; rsp_vld_cnt = 0; rsp_to_cnt = 0; both_cnt = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        Rx_valid = 1'b1;
        RX_out   = b;
        @(negedge CLK);
        Rx_valid = 1'b0;
        RX_out   = 8'($urandom);
    endtask

    task automatic wait_tx(input int n, output bit to);
        int cnt = 0;
        while (tx_q.size() < n && cnt < c_WAIT_MAX) begin @(negedge CLK); cnt++; end
        to = (tx_q.size() < n);
    endtask

    task automatic wait_idle(output bit to);
        int cnt = 0;
        while (!CMD_READY && cnt < c_WAIT_MAX) begin @(negedge CLK); cnt++; end
        to = !CMD_READY;
        repeat (2) @(negedge CLK);
    endtask

    task automatic start_cmd(input vec_t v, input string tag);
        int cnt = 0;
        while (!CMD_READY && cnt < c_WAIT_MAX) begin @(negedge CLK); cnt++; end
        chk({tag, "_ready_wait"}, {31'd0, !CMD_READY}, 32'd0);
        CMD_VLD = 1'b1; CMD_TYPE = v.t; CMD_ADDR = v.ad; CMD_DATA = v.dt;
        CMD_OP_A = v.a; CMD_OP_B = v.b; CMD_FUNC = v.f;
        @(negedge CLK);
        CMD_VLD = 1'b0; CMD_TYPE = 2'($urandom); CMD_ADDR = 8'($urandom);
        CMD_DATA = 8'($urandom); CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom);
        CMD_FUNC = 4'($urandom);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, "_frame_len"}, tx_q.size(), v.flen);
        for (int i = 0; i < v.flen; i++)
            chk($sformatf("%s_tx_byte%0d", tag, i), (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hDEAD, {24'd0, v.fr[i]});
        chk({tag, "_rsp_vld_cnt"}, rsp_vld_cnt, v.exp_vld);
        chk({tag, "_timeout_cnt"}, rsp_to_cnt, v.exp_to);
        chk({tag, "_rsp_data"}, {16'd0, RSP_DATA}, {16'd0, v.exp_rsp});
        if (v.exp_vld != 0) chk({tag, "_rsp_at_vld"}, {16'd0, rsp_at_vld}, {16'd0, v.exp_rsp});
        chk({tag, "_tx_while_busy"}, busy_viol, 0);
        chk({tag, "_vld_and_timeout"}, both_cnt, 0);
        model_rsp = v.exp_rsp;
    endtask

    task automatic finish_cmd(input vec_t v, input string tag);
        bit to;
        if (v.junk) begin
            wait_tx(1, to);
            rx_byte(8'hEE);
        end
        wait_tx(v.flen, to);
        chk({tag, "_tx_wait"}, {31'd0, to}, 32'd0);
        if (v.nrx >= 1) begin repeat (v.d0) @(negedge CLK); rx_byte(v.r0); end
        if (v.nrx >= 2) begin repeat (v.d1) @(negedge CLK); rx_byte(v.r1); end
        wait_idle(to);
        chk({tag, "_idle_wait"}, {31'd0, to}, 32'd0);
        check_result(v, tag);
    endtask

    task automatic do_cmd(input vec_t v, input string tag);
        clear_mon();
        start_cmd(v, tag);
        finish_cmd(v, tag);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        bit   to;
        int   cyc;
        int   viol;

        //      t  ad    dt    a     b     f    nrx r0    r1    d0  d1 jk fl  fr0   fr1   fr2   fr3   rsp      vld to
        tbl[0] = mk(0, 'h05, 'h3C, 0,    0,    0,   0, 0,    0,    0,  0, 0, 3, 'hAA, 'h05, 'h3C, 0,    'h0000, 0, 0);
        tbl[1] = mk(1, 'h02, 0,    0,    0,    0,   1, 'h7E, 0,    4,  0, 0, 2, 'hBB, 'h02, 0,    0,    'h007E, 1, 0);
        tbl[2] = mk(2, 0,    0,    'h0A, 'h05, 0,   2, 'h0F, 'h00, 12, 5, 0, 4, 'hCC, 'h0A, 'h05, 'h00, 'h000F, 1, 0);
        tbl[3] = mk(3, 0,    0,    0,    0,    'hA, 2, 'h34, 'h56, 13, 3, 0, 2, 'hDD, 'h0A, 0,    0,    'h5634, 1, 0);
        tbl[4] = mk(0, 'hFF, 'h00, 0,    0,    0,   0, 0,    0,    0,  0, 0, 3, 'hAA, 'hFF, 'h00, 0,    'h5634, 0, 0);
        tbl[5] = mk(2, 0,    0,    'hFF, 'hFF, 'hF, 2, 'hAB, 'hCD, 14, 9, 1, 4, 'hCC, 'hFF, 'hFF, 'h0F, 'hCDAB, 1, 0);
        tbl[6] = mk(1, 'h80, 0,    0,    0,    0,   1, 'h9A, 0,    3,  0, 1, 2, 'hBB, 'h80, 0,    0,    'h009A, 1, 0);
        tbl[7] = mk(3, 0,    0,    0,    0,    1,   2, 'h11, 'h22, 3,  2, 0, 2, 'hDD, 'h01, 0,    0,    'h2211, 1, 0);

        // Reset values
        repeat (3) @(negedge CLK);
        chk("reset_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        chk("reset_tx_vld", {31'd0, TX_VLD}, 32'd0);
        chk("reset_tx_in", {24'd0, TX_IN}, 32'd0);
        chk("reset_rsp_data", {16'd0, RSP_DATA}, 32'd0);
        chk("reset_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("reset_rsp_timeout", {31'd0, RSP_TIMEOUT}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) do_cmd(tbl[i], $sformatf("vec%0d", i));

        // Timeout: one byte of a two-byte response, then silence
        v = model(mk(3, 0, 0, 0, 0, 3, 1, 'h12, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), model_rsp);
        clear_mon();
        start_cmd(v, "tmo");
        wait_tx(v.flen, to);
        chk("tmo_tx_wait", {31'd0, to}, 32'd0);
        repeat (v.d0) @(negedge CLK);
        rx_byte(8'h12);
        cyc = 0;
        while (!RSP_TIMEOUT && cyc < 100) begin @(negedge CLK); cyc++; end
        chk("tmo_cycles_after_byte", cyc, c_TIMEOUT);
        chk("tmo_rsp_low_byte", {24'd0, RSP_DATA[7:0]}, 32'h12);
        wait_idle(to);
        check_result(v, "tmo");

        // BUSY held high before the first byte while the request port is toggled
        v = model(mk(2, 0, 0, 'h11, 'h22, 5, 2, 'h77, 'h88, 12, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), model_rsp);
        busy_force = 1'b1;
        @(negedge CLK);
        clear_mon();
        start_cmd(v, "busy");
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            CMD_VLD = ~CMD_VLD; CMD_TYPE = 2'($urandom); CMD_ADDR = 8'($urandom);
            CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom); CMD_FUNC = 4'($urandom);
            @(negedge CLK);
            if (TX_VLD || CMD_READY) viol++;
        end
        chk("busy_hold_no_tx_no_ready", viol, 0);
        CMD_VLD = 1'b0;
        busy_force = 1'b0;
        finish_cmd(v, "busy");

        // Asynchronous reset during the second byte of an ALU command
        v = model(mk(2, 0, 0, 5, 6, 7, 2, 1, 2, 12, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), model_rsp);
        clear_mon();
        start_cmd(v, "rst");
        wait_tx(2, to);
        chk("rst_tx_wait", {31'd0, to}, 32'd0);
        #1 RST = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        chk("rst_mid_tx_vld", {31'd0, TX_VLD}, 32'd0);
        chk("rst_mid_tx_in", {24'd0, TX_IN}, 32'd0);
        chk("rst_mid_rsp_data", {16'd0, RSP_DATA}, 32'd0);
        chk("rst_mid_strobes", {30'd0, RSP_VLD, RSP_TIMEOUT}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        model_rsp = 16'h0000;
        clear_mon();
        repeat (20) @(negedge CLK);
        chk("rst_after_no_tx", tx_q.size(), 0);
        chk("rst_after_no_rsp", rsp_vld_cnt + rsp_to_cnt, 0);
        v = model(mk(1, 'h33, 0, 0, 0, 0, 1, 'h5A, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), model_rsp);
        chk("rst_fresh_expect", {16'd0, v.exp_rsp}, 32'h005A);
        do_cmd(v, "rst_fresh");

        // Randomized commands against the reference model
        for (int n = 0; n < 25; n++) begin
            v.t = 2'($urandom); v.ad = 8'($urandom); v.dt = 8'($urandom);
            v.a = 8'($urandom); v.b = 8'($urandom); v.f = 4'($urandom);
            v.r0 = 8'($urandom); v.r1 = 8'($urandom);
            v.d0 = $urandom_range(3, 15); v.d1 = $urandom_range(1, 15);
            v.junk = 1'($urandom);
            v.nrx = (v.t == 2'd0) ? 0 : (v.t == 2'd1) ? 1 : 2;
            v = model(v, model_rsp);
            do_cmd(v, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/host_cmd_master.md
Name: host_cmd_master

Overview:
Host-side command initiator for the UART register/ALU command protocol: the end that sends command frames, not the one that decodes them. It accepts one command at a time on a parallel request interface and serializes it byte-by-byte into the UART transmitter. It then collects the response bytes from the UART receiver and returns them as a single result. Used in the host/bench-side subsystem and as an on-chip loopback exerciser for the system controller.

Parameters:
TO_W, 16, width of the response timeout counter
TIMEOUT, 50000, cycles allowed in RX_WAIT without a received byte before abort (1..2^TO_W-1)

Ports:
CLK  in  1  system clock
RST  in  1  async active-low reset
CMD_VLD  in  1  command request
CMD_READY  out  1  high only in IDLE; command accepted when CMD_VLD & CMD_READY
CMD_TYPE  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operands
CMD_ADDR  in  8  register address (types 0,1)
CMD_DATA  in  8  write data (type 0)
CMD_OP_A  in  8  operand A (type 2)
CMD_OP_B  in  8  operand B (type 2)
CMD_FUNC  in  4  ALU function (types 2,3)
TX_IN  out  8  byte to UART TX
TX_VLD  out  1  one-cycle byte strobe to UART TX
BUSY  in  1  UART TX busy
RX_out  in  8  byte from UART RX
Rx_valid  in  1  one-cycle RX byte strobe
RSP_DATA  out  16  response data
RSP_VLD  out  1  one-cycle response strobe
RSP_TIMEOUT  out  1  one-cycle abort strobe

Behaviour:
- Reset (RST=0, async): state IDLE; CMD_READY=1; TX_VLD=0; TX_IN=0; RSP_DATA=0; RSP_VLD=0; RSP_TIMEOUT=0; byte index, RX count and timeout counter =0.
- Frames, sent in this order: type0 = AA, ADDR, DATA; type1 = BB, ADDR; type2 = CC, OP_A, OP_B, {4'h0,FUNC}; type3 = DD, {4'h0,FUNC}.
- Expected response length: type0 = 0 bytes; type1 = 1 byte; types 2,3 = 2 bytes, LSB first.
- On acceptance, all CMD_* fields are registered. Later changes on the inputs have no effect until the next acceptance.
- States: IDLE -> SEND -> WAIT_ACC -> WAIT_DONE -> (SEND | RX_WAIT | IDLE); RX_WAIT -> IDLE.
- SEND: the first cycle with BUSY=0 drives TX_VLD=1 for exactly one cycle, with TX_IN = current frame byte, then goes to WAIT_ACC. TX_IN holds its value until the next TX_VLD. While BUSY=1, SEND waits.
- WAIT_ACC: waits for BUSY=1, then goes to WAIT_DONE.
- WAIT_DONE: waits for BUSY=0, then increments the byte index.
  - Bytes remaining -> SEND.
  - Last byte and type0 -> IDLE. No RSP_VLD for writes.
  - Last byte otherwise -> RX_WAIT.
- Rx_valid is honoured in WAIT_DONE of the final byte (types 1–3) and in RX_WAIT. At all other times it is ignored.
  - Type1: RSP_DATA={8'h00,RX_out}.
  - Types 2/3: first byte -> RSP_DATA[7:0], second byte -> RSP_DATA[15:8].
- When the last expected byte is captured, RSP_VLD pulses 1 cycle with final RSP_DATA valid that same cycle, and the state goes to IDLE. CMD_READY=1 the next cycle.
- RSP_DATA holds its value until the next captured byte.
- Timeout:
  - The counter runs only in RX_WAIT and clears on entry and on every honoured Rx_valid.
  - When it reaches TIMEOUT-1 with no byte that cycle: RSP_TIMEOUT pulses 1 cycle, RSP_VLD stays 0, the state goes to IDLE, and RSP_DATA keeps any partial byte.
  - Rx_valid in the same cycle as the timeout condition wins: the byte is captured and no timeout occurs.
- No timeout on BUSY handshakes (the UART TX guarantees progress).
- RST low mid-frame aborts immediately to reset values. No partial strobes after release.
- RSP_VLD and RSP_TIMEOUT are never high together. Back-to-back commands are allowed; the next command can be accepted the cycle after returning to IDLE.

Test Plan:
- Type0 ADDR=05 DATA=3C, bench TX model BUSY 1 for 10 cycles per byte -> TX_VLD pulses with AA,05,3C, each only while BUSY=0. No RSP_VLD; CMD_READY back to 1.
- Type1 ADDR=02, RX returns 7E -> TX bytes BB,02. RSP_VLD once with RSP_DATA=007E.
- Type2 A=0A B=05 FUNC=0, RX returns 0F then 00 -> TX bytes CC,0A,05,00. RSP_DATA=000F, single RSP_VLD.
- Type3 FUNC=3 with TIMEOUT=20, RX returns one byte 12 then silence -> TX DD,03. RSP_TIMEOUT exactly 20 cycles after byte 12, RSP_VLD never asserted, RSP_DATA[7:0]=12.
- BUSY held high 50 cycles before the first byte, and CMD_VLD toggled with new fields while not ready -> no TX_VLD while BUSY=1. Frame uses the originally accepted fields.
- RST asserted during the second TX byte of a type2 command -> all outputs reset values asynchronously. After release, a fresh type1 command completes normally.
